// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes and the read-channel FSM encoding.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StResp
  } rd_state_e;

endpackage

// File: rtl/axi_read_logic.sv
// AXI4-Lite read channel in front of a synchronous register file, one transaction in flight.
// Define AXI_RD_ADDR_CHECK_EN to answer out-of-range indices with SLVERR instead of wrapping.
module axi_read_logic
  import axi_lite_pkg::*;
#(
  parameter int unsigned number_of_register = 64,
  parameter int unsigned DATA_WIDTH         = 32
) (
  input  logic                  axi_clk,
  input  logic                  rstn,
  input  logic [7:0]            read_addr,
  input  logic                  read_addr_valid,
  output logic                  read_addr_ready,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic [1:0]            read_resp,
  output logic                  read_data_valid,
  input  logic                  read_data_ready,
  output logic [5:0]            reg_rd_addr,
  output logic                  reg_rd_en,
  input  logic [DATA_WIDTH-1:0] reg_rd_data
);

  rd_state_e             state_q, state_d;
  logic [5:0]            idx_q, idx_d;
  logic                  oor_q, oor_d;
  logic                  rdy_q, rdy_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [1:0]            resp_q, resp_d;

  logic [5:0] ar_idx;
  logic [5:0] ar_idx_eff;
  logic       ar_oor;
  logic       unused_addr_lsb;

  // Byte lanes are irrelevant: an unaligned address reads its containing word.
  assign ar_idx          = read_addr[7:2];
  assign unused_addr_lsb = ^read_addr[1:0];

`ifdef AXI_RD_ADDR_CHECK_EN
  assign ar_oor     = 32'(ar_idx) >= number_of_register;
  assign ar_idx_eff = ar_idx;
`else
  assign ar_oor     = 1'b0;
  assign ar_idx_eff = 6'(32'(ar_idx) % number_of_register);
`endif

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    oor_d     = oor_q;
    data_d    = data_q;
    resp_d    = resp_q;
    reg_rd_en = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (rdy_q && read_addr_valid) begin
          idx_d   = ar_idx_eff;
          oor_d   = ar_oor;
          state_d = StFetch;
        end
      end
      StFetch: begin
        // Register file data is captured on the edge that enters StResp.
        reg_rd_en = ~oor_q;
        state_d   = StResp;
        if (oor_q) begin
          data_d = '0;
          resp_d = RESP_SLVERR;
        end else begin
          data_d = reg_rd_data;
          resp_d = RESP_OKAY;
        end
      end
      StResp: begin
        if (read_data_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // ARREADY is registered so it stays low during reset and rises one edge later.
  assign rdy_d = (state_d == StIdle);

  always_ff @(posedge axi_clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      idx_q   <= '0;
      oor_q   <= 1'b0;
      rdy_q   <= 1'b0;
      data_q  <= '0;
      resp_q  <= RESP_OKAY;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      oor_q   <= oor_d;
      rdy_q   <= rdy_d;
      data_q  <= data_d;
      resp_q  <= resp_d;
    end
  end

  assign read_addr_ready = rdy_q;
  assign read_data_valid = (state_q == StResp);
  assign read_data       = data_q;
  assign read_resp       = resp_q;
  assign reg_rd_addr     = idx_q;

endmodule

// File: tb/tb_axi_read_logic.sv
// Directed bench for axi_read_logic with a 16-entry register space and a behavioural register file.
module tb_axi_read_logic;
  import axi_lite_pkg::*;

  localparam int unsigned NReg = 16;

  logic        axi_clk = 1'b0;
  logic        rstn    = 1'b0;
  logic [7:0]  read_addr = 8'h00;
  logic        read_addr_valid = 1'b0;
  logic        read_addr_ready;
  logic [31:0] read_data;
  logic [1:0]  read_resp;
  logic        read_data_valid;
  logic        read_data_ready = 1'b0;
  logic [5:0]  reg_rd_addr;
  logic        reg_rd_en;
  logic [31:0] reg_rd_data;

  logic [31:0] rf [64];
  int n_total = 0;
  int n_bad   = 0;
  int en_cnt  = 0;

  axi_read_logic #(
    .number_of_register(NReg),
    .DATA_WIDTH        (32)
  ) dut (
    .axi_clk        (axi_clk),
    .rstn           (rstn),
    .read_addr      (read_addr),
    .read_addr_valid(read_addr_valid),
    .read_addr_ready(read_addr_ready),
    .read_data      (read_data),
    .read_resp      (read_resp),
    .read_data_valid(read_data_valid),
    .read_data_ready(read_data_ready),
    .reg_rd_addr    (reg_rd_addr),
    .reg_rd_en      (reg_rd_en),
    .reg_rd_data    (reg_rd_data)
  );

  always #5 axi_clk = ~axi_clk;

  assign reg_rd_data = rf[reg_rd_addr];

  always @(posedge axi_clk) begin
    if (reg_rd_en) en_cnt <= en_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge axi_clk);
    #1;
  endtask

  // Full read with RREADY held high; called one time unit after a clock edge with the block idle.
  task automatic read_txn(input string tag, input logic [7:0] addr, input logic [5:0] e_idx,
                          input logic e_en, input logic [31:0] e_data, input logic [1:0] e_resp);
    int c0;
    c0 = en_cnt;
    check_eq({tag, "_arready_idle"}, 32'(read_addr_ready), 32'd1);
    read_addr       = addr;
    read_addr_valid = 1'b1;
    read_data_ready = 1'b1;
    step();
    read_addr_valid = 1'b0;
    check_eq({tag, "_arready_fetch"}, 32'(read_addr_ready), 32'd0);
    check_eq({tag, "_rd_en"}, 32'(reg_rd_en), 32'(e_en));
    check_eq({tag, "_rd_addr"}, 32'(reg_rd_addr), 32'(e_idx));
    check_eq({tag, "_rvalid_fetch"}, 32'(read_data_valid), 32'd0);
    step();
    check_eq({tag, "_rvalid"}, 32'(read_data_valid), 32'd1);
    check_eq({tag, "_rdata"}, read_data, e_data);
    check_eq({tag, "_rresp"}, 32'(read_resp), 32'(e_resp));
    step();
    check_eq({tag, "_rvalid_done"}, 32'(read_data_valid), 32'd0);
    check_eq({tag, "_arready_done"}, 32'(read_addr_ready), 32'd1);
    check_eq({tag, "_rdata_hold"}, read_data, e_data);
    check_eq({tag, "_en_count"}, 32'(en_cnt - c0), 32'(e_en));
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rf[i] = 32'hA500_0000 | 32'(i);
    rf[0] = 32'h1111_0000;
    rf[1] = 32'h2222_0001;
    rf[2] = 32'hDEAD_BEEF;

    // Reset values while rstn is low.
    #2;
    check_eq("rst_arready", 32'(read_addr_ready), 32'd0);
    check_eq("rst_rvalid", 32'(read_data_valid), 32'd0);
    check_eq("rst_rdata", read_data, 32'd0);
    check_eq("rst_rresp", 32'(read_resp), 32'd0);
    check_eq("rst_rd_en", 32'(reg_rd_en), 32'd0);
    check_eq("rst_rd_addr", 32'(reg_rd_addr), 32'd0);
    @(posedge axi_clk);
    #1;
    rstn = 1'b1;
    check_eq("rel_arready_low", 32'(read_addr_ready), 32'd0);
    step();
    check_eq("rel_arready_high", 32'(read_addr_ready), 32'd1);

    read_txn("single", 8'h08, 6'd2, 1'b1, 32'hDEAD_BEEF, RESP_OKAY);

    // Backpressure: response held for 5 cycles while a second AR waits.
    read_addr       = 8'h0C;
    read_addr_valid = 1'b1;
    read_data_ready = 1'b0;
    step();
    read_addr_valid = 1'b0;
    check_eq("bp_rd_addr", 32'(reg_rd_addr), 32'd3);
    step();
    check_eq("bp_rvalid", 32'(read_data_valid), 32'd1);
    check_eq("bp_rdata", read_data, 32'hA500_0003);
    read_addr       = 8'h10;
    read_addr_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      check_eq("bp_hold_rvalid", 32'(read_data_valid), 32'd1);
      check_eq("bp_hold_rdata", read_data, 32'hA500_0003);
      check_eq("bp_hold_arready", 32'(read_addr_ready), 32'd0);
      check_eq("bp_hold_rd_en", 32'(reg_rd_en), 32'd0);
    end
    read_data_ready = 1'b1;
    step();
    check_eq("bp_done_rvalid", 32'(read_data_valid), 32'd0);
    check_eq("bp_done_arready", 32'(read_addr_ready), 32'd1);
    step();
    read_addr_valid = 1'b0;
    check_eq("bp_second_rd_en", 32'(reg_rd_en), 32'd1);
    check_eq("bp_second_rd_addr", 32'(reg_rd_addr), 32'd4);
    step();
    check_eq("bp_second_rdata", read_data, 32'hA500_0004);
    step();

    // Back-to-back: second AR issued in the cycle right after the first R handshake.
    read_txn("b2b0", 8'h00, 6'd0, 1'b1, 32'h1111_0000, RESP_OKAY);
    read_txn("b2b1", 8'h04, 6'd1, 1'b1, 32'h2222_0001, RESP_OKAY);

`ifdef AXI_RD_ADDR_CHECK_EN
    read_txn("oor", 8'h40, 6'd16, 1'b0, 32'h0000_0000, RESP_SLVERR);
`else
    read_txn("oor", 8'h40, 6'd0, 1'b1, 32'h1111_0000, RESP_OKAY);
`endif

    read_txn("unaligned", 8'h0B, 6'd2, 1'b1, 32'hDEAD_BEEF, RESP_OKAY);

    // Reset in the middle of a stalled response.
    read_addr       = 8'h14;
    read_addr_valid = 1'b1;
    read_data_ready = 1'b0;
    step();
    read_addr_valid = 1'b0;
    step();
    check_eq("mid_rvalid", 32'(read_data_valid), 32'd1);
    check_eq("mid_rdata", read_data, 32'hA500_0005);
    #2;
    rstn = 1'b0;
    #1;
    check_eq("mid_rst_rvalid", 32'(read_data_valid), 32'd0);
    check_eq("mid_rst_rdata", read_data, 32'd0);
    check_eq("mid_rst_arready", 32'(read_addr_ready), 32'd0);
    @(posedge axi_clk);
    #1;
    rstn = 1'b1;
    step();
    read_txn("post_rst", 8'h18, 6'd6, 1'b1, 32'hA500_0006, RESP_OKAY);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
